// File: rtl/rvdt_pkg.sv
// Shared types and helpers for the RVDT ratiometric position calculator.
package rvdt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        OUTPUT
    } ratio_state_t;

    // Largest positive Q1.(w-1) code; the negative side is kept symmetric.
    function automatic int ratio_max(input int out_width);
        return (1 << (out_width - 1)) - 1;
    endfunction

endpackage

// File: rtl/rvdt_ratio_calc_if.sv
// Sample-in / ratio-out bundle between the demodulators, the ratio block and readout.
interface rvdt_ratio_calc_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 14
);
    logic [IN_WIDTH-1:0]         s1_i;
    logic                        s1_valid_i;
    logic [IN_WIDTH-1:0]         s2_i;
    logic                        s2_valid_i;
    logic signed [OUT_WIDTH-1:0] ratio_o;
    logic                        valid_o;
    logic                        busy_o;
    logic                        div_zero_o;
    logic                        pair_error_o;

    modport master (
        output s1_i, s1_valid_i, s2_i, s2_valid_i,
        input  ratio_o, valid_o, busy_o, div_zero_o, pair_error_o
    );

    modport slave (
        input  s1_i, s1_valid_i, s2_i, s2_valid_i,
        output ratio_o, valid_o, busy_o, div_zero_o, pair_error_o
    );
endinterface

// File: rtl/seq_udiv.sv
// Unsigned restoring divider producing Q_W fractional quotient bits, one per cycle.
module seq_udiv #(
    parameter int NUM_W = 17,
    parameter int DEN_W = 17,
    parameter int Q_W   = 13
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    output logic [Q_W-1:0]   quot_o,
    output logic             done_o
);
    localparam int CNT_W = (Q_W > 1) ? $clog2(Q_W) : 1;

    logic [DEN_W-1:0] rem;
    logic [DEN_W-1:0] den;
    logic [Q_W-1:0]   quot;
    logic [CNT_W-1:0] cnt;
    logic             active;
    logic             done;
    logic [DEN_W:0]   trial;

    assign trial = {rem, 1'b0};

    // Numerator is expected to be <= denominator, so the quotient is a pure fraction.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rem    <= '0;
            den    <= '0;
            quot   <= '0;
            cnt    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else if (start_i) begin
            rem    <= DEN_W'(num_i);
            den    <= den_i;
            quot   <= '0;
            cnt    <= '0;
            active <= 1'b1;
            done   <= 1'b0;
        end else if (active) begin
            if (trial >= {1'b0, den}) begin
                rem  <= DEN_W'(trial - {1'b0, den});
                quot <= {quot[Q_W-2:0], 1'b1};
            end else begin
                rem  <= DEN_W'(trial);
                quot <= {quot[Q_W-2:0], 1'b0};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(Q_W - 1)) begin
                active <= 1'b0;
                done   <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign quot_o = quot;
    assign done_o = done;
endmodule

// File: rtl/rvdt_ratio_calc.sv
// Pairs S1/S2 demodulated amplitudes and computes (S1-S2)/(S1+S2) as a signed Q1 fraction.
module rvdt_ratio_calc
    import rvdt_pkg::*;
#(
    parameter int IN_WIDTH     = 16,
    parameter int OUT_WIDTH    = 14,
    parameter int PAIR_TIMEOUT = 4095
) (
    input logic               clk_i,
    input logic               reset_ni,
    rvdt_ratio_calc_if.slave  bus
);
    localparam int SUM_W  = IN_WIDTH + 1;
    localparam int FRAC_W = OUT_WIDTH - 1;
    localparam int TMO_W  = $clog2(PAIR_TIMEOUT + 1);
    localparam logic [OUT_WIDTH-1:0] RMAX = OUT_WIDTH'(ratio_max(OUT_WIDTH));

    ratio_state_t          state;
    logic [IN_WIDTH-1:0]   s1_hold, s2_hold;
    logic                  have_s1, have_s2;
    logic [TMO_W-1:0]      tmo_cnt;
    logic signed [OUT_WIDTH-1:0] ratio_q;
    logic                  valid_q, busy_q, div_zero_q, pair_error_q;
    logic                  neg_r, sat_r, zero_r;

    logic                  load, h1, h2, have_s1_n, have_s2_n;
    logic                  overwrite, lone, any_strobe, tmo_hit;
    logic [SUM_W-1:0]      sum;
    logic [IN_WIDTH-1:0]   mag;
    logic                  neg;
    logic [FRAC_W-1:0]     quot;
    logic                  div_done;
    logic [OUT_WIDTH-1:0]  q_mag;

    // A pair is consumed from OUTPUT as well as IDLE so back-to-back pairs keep full throughput.
    always_comb begin
        load       = ((state == IDLE) || (state == OUTPUT)) && have_s1 && have_s2;
        h1         = have_s1 && !load;
        h2         = have_s2 && !load;
        have_s1_n  = h1 || bus.s1_valid_i;
        have_s2_n  = h2 || bus.s2_valid_i;
        overwrite  = (bus.s1_valid_i && h1) || (bus.s2_valid_i && h2);
        any_strobe = bus.s1_valid_i || bus.s2_valid_i;
        lone       = have_s1_n ^ have_s2_n;
        tmo_hit    = lone && !any_strobe && (tmo_cnt == TMO_W'(PAIR_TIMEOUT - 1));
        sum        = SUM_W'(s1_hold) + SUM_W'(s2_hold);
        neg        = s2_hold > s1_hold;
        mag        = neg ? (s2_hold - s1_hold) : (s1_hold - s2_hold);
        q_mag      = sat_r ? RMAX : {1'b0, quot};
    end

    // Capture and timeout run in every FSM state; a fresh strobe restarts the wait.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s1_hold      <= '0;
            s2_hold      <= '0;
            have_s1      <= 1'b0;
            have_s2      <= 1'b0;
            tmo_cnt      <= '0;
            pair_error_q <= 1'b0;
        end else begin
            if (bus.s1_valid_i) s1_hold <= bus.s1_i;
            if (bus.s2_valid_i) s2_hold <= bus.s2_i;
            have_s1      <= have_s1_n && !tmo_hit;
            have_s2      <= have_s2_n && !tmo_hit;
            pair_error_q <= overwrite || tmo_hit;
            if (!lone || any_strobe || tmo_hit) tmo_cnt <= '0;
            else                                tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    seq_udiv #(
        .NUM_W (SUM_W),
        .DEN_W (SUM_W),
        .Q_W   (FRAC_W)
    ) u_div (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .start_i  (load),
        .num_i    (SUM_W'(mag)),
        .den_i    (sum),
        .quot_o   (quot),
        .done_o   (div_done)
    );

    // Sign, saturation and zero flags are latched at load since the hold regs may refill.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state      <= IDLE;
            ratio_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            div_zero_q <= 1'b0;
            neg_r      <= 1'b0;
            sat_r      <= 1'b0;
            zero_r     <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            div_zero_q <= 1'b0;
            case (state)
                IDLE, OUTPUT: begin
                    if (load) begin
                        state  <= DIVIDE;
                        busy_q <= 1'b1;
                        neg_r  <= neg;
                        sat_r  <= (SUM_W'(mag) == sum);
                        zero_r <= (sum == '0);
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                DIVIDE: begin
                    busy_q <= 1'b1;
                    if (div_done) begin
                        state      <= OUTPUT;
                        valid_q    <= 1'b1;
                        div_zero_q <= zero_r;
                        if (zero_r)     ratio_q <= '0;
                        else if (neg_r) ratio_q <= -$signed(q_mag);
                        else            ratio_q <= $signed(q_mag);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ratio_o      = ratio_q;
    assign bus.valid_o      = valid_q;
    assign bus.busy_o       = busy_q;
    assign bus.div_zero_o   = div_zero_q;
    assign bus.pair_error_o = pair_error_q;
endmodule

// File: tb/tb_rvdt_ratio_calc.sv
// Directed bench for rvdt_ratio_calc with an arithmetic reference model and scoreboard.
module tb_rvdt_ratio_calc;
    localparam int IW = 16;
    localparam int OW = 14;
    localparam int PT = 100;
    localparam int FS = 1 << (OW - 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rvdt_ratio_calc_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus();

    rvdt_ratio_calc #(
        .IN_WIDTH     (IW),
        .OUT_WIDTH    (OW),
        .PAIR_TIMEOUT (PT)
    ) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    int checks       = 0;
    int failures     = 0;
    int exp_ratio_q[$];
    bit exp_dz_q[$];
    int hold_ratio   = 0;
    int err_expected = 0;
    int err_seen     = 0;
    bit m_have1 = 1'b0, m_have2 = 1'b0;
    int m_s1 = 0, m_s2 = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Ratio straight from the definition: truncate |S1-S2|*FS/(S1+S2), clamp, reapply sign.
    function automatic void modelRatio(input int a, input int b, output int r, output bit dz);
        longint sum, d, mag, q;
        sum = longint'(a) + longint'(b);
        d   = longint'(a) - longint'(b);
        mag = (d < 0) ? -d : d;
        if (sum == 0) begin
            r  = 0;
            dz = 1'b1;
        end else begin
            q  = (mag * FS) / sum;
            if (q > FS - 1) q = FS - 1;
            r  = (d < 0) ? -int'(q) : int'(q);
            dz = 1'b0;
        end
    endfunction

    task automatic driveInputs(input bit v1, input int a, input bit v2, input int b);
        int r;
        bit dz;
        bus.s1_valid_i = v1;
        bus.s1_i       = IW'(a);
        bus.s2_valid_i = v2;
        bus.s2_i       = IW'(b);
        if (v1) begin
            if (m_have1) err_expected++;
            m_have1 = 1'b1;
            m_s1    = a;
        end
        if (v2) begin
            if (m_have2) err_expected++;
            m_have2 = 1'b1;
            m_s2    = b;
        end
        if (m_have1 && m_have2) begin
            modelRatio(m_s1, m_s2, r, dz);
            exp_ratio_q.push_back(r);
            exp_dz_q.push_back(dz);
            m_have1 = 1'b0;
            m_have2 = 1'b0;
        end
    endtask

    task automatic applyStimulus(input bit v1, input int a, input bit v2, input int b);
        driveInputs(v1, a, v2, b);
        @(negedge clk);
        driveInputs(1'b0, 0, 1'b0, 0);
    endtask

    task automatic waitValid(input int maxc, output int cyc, output int r, output int dz);
        cyc = -1;
        r   = 0;
        dz  = 0;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (bus.valid_o) begin
                cyc = k;
                r   = int'($signed(bus.ratio_o));
                dz  = int'(bus.div_zero_o);
                break;
            end
        end
        if (cyc < 0) checkOutput("valid_seen", int'(bus.valid_o), 1);
    endtask

    // Scoreboard: every valid pops the next expected pair; between valids the ratio must hold.
    always @(negedge clk) begin : compare
        int er;
        bit ed;
        if (rst_n) begin
            if (bus.pair_error_o) err_seen++;
            if (bus.valid_o) begin
                if (exp_ratio_q.size() == 0) begin
                    checkOutput("unexpected_valid", int'(bus.valid_o), 0);
                end else begin
                    er = exp_ratio_q.pop_front();
                    ed = exp_dz_q.pop_front();
                    checkOutput("ratio", int'($signed(bus.ratio_o)), er);
                    checkOutput("div_zero", int'(bus.div_zero_o), int'(ed));
                    hold_ratio = er;
                end
            end else begin
                checkOutput("ratio_hold", int'($signed(bus.ratio_o)), hold_ratio);
                checkOutput("div_zero_idle", int'(bus.div_zero_o), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c, r, dz, pe_k, err_before;
        real ideal, diff;

        driveInputs(1'b0, 0, 1'b0, 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ratio", int'($signed(bus.ratio_o)), 0);
        checkOutput("rst_valid", int'(bus.valid_o), 0);
        checkOutput("rst_busy", int'(bus.busy_o), 0);
        checkOutput("rst_div_zero", int'(bus.div_zero_o), 0);
        checkOutput("rst_pair_error", int'(bus.pair_error_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] same-cycle pair");
        applyStimulus(1'b1, 12000, 1'b1, 4000);
        waitValid(30, c, r, dz);
        checkOutput("t1_latency", c, 15);
        checkOutput("t1_ratio", r, 4096);
        repeat (3) @(negedge clk);

        $display("[TB] staggered pairs");
        applyStimulus(1'b1, 4000, 1'b0, 0);
        repeat (9) @(negedge clk);
        applyStimulus(1'b0, 0, 1'b1, 12000);
        waitValid(30, c, r, dz);
        checkOutput("t2_latency", c, 15);
        checkOutput("t2_ratio_neg", r, -4096);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 2000, 1'b1, 1000);
        waitValid(30, c, r, dz);
        checkOutput("t2_ratio_trunc", r, 2730);
        repeat (2) @(negedge clk);

        $display("[TB] saturation and zero sum");
        applyStimulus(1'b1, 5000, 1'b1, 0);
        waitValid(30, c, r, dz);
        checkOutput("t3_sat_pos", r, 8191);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 0, 1'b1, 5000);
        waitValid(30, c, r, dz);
        checkOutput("t3_sat_neg", r, -8191);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 0, 1'b1, 0);
        waitValid(30, c, r, dz);
        checkOutput("t3_zero_ratio", r, 0);
        checkOutput("t3_zero_flag", dz, 1);
        checkOutput("t3_zero_latency", c, 15);
        repeat (2) @(negedge clk);

        $display("[TB] pair timeout and overwrite");
        err_before = err_seen;
        applyStimulus(1'b1, 1234, 1'b0, 0);
        pe_k = -1;
        for (int k = 1; k <= PT + 10; k++) begin
            @(negedge clk);
            if (bus.pair_error_o && pe_k < 0) pe_k = k;
        end
        m_have1 = 1'b0;
        err_expected++;
        checkOutput("t4_timeout_window", int'(pe_k >= PT - 1 && pe_k <= PT + 2), 1);
        checkOutput("t4_timeout_pulses", err_seen - err_before, 1);
        applyStimulus(1'b1, 2000, 1'b1, 1000);
        waitValid(30, c, r, dz);
        checkOutput("t4_after_timeout", r, 2730);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 9000, 1'b0, 0);
        @(negedge clk);
        applyStimulus(1'b1, 3000, 1'b0, 0);
        @(negedge clk);
        applyStimulus(1'b0, 0, 1'b1, 1000);
        waitValid(30, c, r, dz);
        checkOutput("t4_overwrite_ratio", r, 4096);
        checkOutput("t4_err_count", err_seen, err_expected);
        repeat (2) @(negedge clk);

        $display("[TB] back-to-back pairs");
        applyStimulus(1'b1, 12000, 1'b1, 4000);
        checkOutput("t5_busy_0", int'(bus.busy_o), 0);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t5_busy_%0d", k), int'(bus.busy_o), int'(k <= 30));
            checkOutput($sformatf("t5_valid_%0d", k), int'(bus.valid_o), int'(k == 15 || k == 30));
            if (k == 15) checkOutput("t5_ratio_a", int'($signed(bus.ratio_o)), 4096);
            if (k == 30) checkOutput("t5_ratio_b", int'($signed(bus.ratio_o)), -4096);
            if (k == 4)      driveInputs(1'b1, 1000, 1'b1, 3000);
            else if (k == 5) driveInputs(1'b0, 0, 1'b0, 0);
        end
        checkOutput("t5_queue_drained", exp_ratio_q.size(), 0);

        $display("[TB] reset during divide");
        applyStimulus(1'b1, 30000, 1'b1, 10000);
        repeat (6) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_ratio", int'($signed(bus.ratio_o)), 0);
        checkOutput("t6_rst_busy", int'(bus.busy_o), 0);
        checkOutput("t6_rst_valid", int'(bus.valid_o), 0);
        exp_ratio_q.delete();
        exp_dz_q.delete();
        hold_ratio = 0;
        m_have1 = 1'b0;
        m_have2 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t6_rst_hold_valid", int'(bus.valid_o), 0);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 7000, 1'b1, 3000);
        waitValid(30, c, r, dz);
        checkOutput("t6_fresh_ratio", r, 3276);
        ideal = (7000.0 - 3000.0) / (7000.0 + 3000.0) * real'(FS);
        diff  = real'(r) - ideal;
        if (diff < 0.0) diff = -diff;
        checkOutput("t6_real_err_le_1lsb", int'(diff <= 1.0), 1);
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
